led_rr_sched: RTL and testbench

Round-robin scheduler that shares the board LED output bus among several producers, such as the accumulator status, the counter slice and debug sources. Each requester holds a request and presents its LED pattern. The scheduler grants one requester at a time for a bounded dwell, drives the registered LED bus from the owner's data, and inserts one idle turnaround cycle between owners. It sits between the datapath blocks and the top-level LED port.

---
 rtl/led_rr_sched.sv | 119 +++++++++++
 tb/tb_led_rr_sched.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/led_rr_sched.sv
// Round-robin owner of the board LED bus: grants one requester for a bounded dwell,
// registers the owner's pattern onto led, and inserts one idle turnaround cycle between owners.
module led_rr_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned W     = 4,
  parameter int unsigned DWELL = 8,
  localparam int unsigned CNT_W = $clog2(DWELL) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   done,
  input  logic [NREQ*W-1:0] data,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      led,
  output logic              led_valid,
  output logic              busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [W-1:0]      led_q, led_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [W-1:0]      data_a [NREQ];
  logic              found;
  logic [PW-1:0]     sel;
  logic              release_grant;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      data_a[i] = data[i*W +: W];
    end
  end

  // First set request at or after ptr, wrapping modulo NREQ.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr_q) + i) % NREQ;
      if (!found && req[PW'(idx)]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
  end

  assign release_grant = (cnt_q == CNT_W'(DWELL - 1)) || done[owner_q] || !req[owner_q];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    led_d   = led_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, GAP: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = NREQ'(1) << sel;
          led_d   = data_a[sel];
          owner_d = sel;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      GRANT: begin
        if (release_grant) begin
          state_d = GAP;
          gnt_d   = '0;
          ptr_d   = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          led_d = data_a[owner_q];
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      led_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      led_q   <= led_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign led       = led_q;
  assign led_valid = |gnt_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_led_rr_sched.sv
// Directed bench for led_rr_sched (NREQ=4, W=4, DWELL=8) with hand-computed expectations.
module tb_led_rr_sched;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned W     = 4;
  localparam int unsigned DWELL = 8;

  logic              clock;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   done;
  logic [NREQ*W-1:0] data;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      led;
  logic              led_valid;
  logic              busy;

  logic [W-1:0]      data_a [NREQ];

  int checks;
  int errors;

  always_comb begin
    for (int i = 0; i < NREQ; i++) data[i*W +: W] = data_a[i];
  end

  led_rr_sched #(.NREQ(NREQ), .W(W), .DWELL(DWELL)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .done      (done),
    .data      (data),
    .gnt       (gnt),
    .led       (led),
    .led_valid (led_valid),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Outputs are sampled 1 time unit after the edge; inputs change there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    done  = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] pat;
    logic [W-1:0] last;
    checks = 0;
    errors = 0;
    for (int i = 0; i < NREQ; i++) data_a[i] = '0;
    do_reset();

    // Reset state
    check("rst_gnt",   32'(gnt), 32'h0);
    check("rst_led",   32'(led), 32'h0);
    check("rst_valid", 32'(led_valid), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);

    // 1: lone requester 2, led lags data by one cycle
    req  = 4'b0100;
    last = '0;
    for (int k = 1; k <= 8; k++) begin
      pat = W'(k + 3);
      data_a[2] = pat;
      data_a[1] = ~pat;
      tick();
      check("t1_gnt", 32'(gnt), 32'h4);
      check("t1_led", 32'(led), 32'(pat));
      last = pat;
    end
    data_a[2] = 4'hE;
    tick();
    check("t1_gap_gnt",   32'(gnt), 32'h0);
    check("t1_gap_led",   32'(led), 32'(last));
    check("t1_gap_valid", 32'(led_valid), 32'h0);
    check("t1_gap_busy",  32'(busy), 32'h1);
    for (int k = 10; k <= 17; k++) begin
      tick();
      check("t1_regnt", 32'(gnt), 32'h4);
    end
    check("t1_regnt_led", 32'(led), 32'hE);
    req = '0;
    tick();
    check("t1_rel_gnt", 32'(gnt), 32'h0);
    tick();
    check("t1_idle_busy", 32'(busy), 32'h0);
    check("t1_idle_led",  32'(led), 32'hE);

    // 2: full contention, rotation with pointer wrap
    do_reset();
    for (int i = 0; i < NREQ; i++) data_a[i] = W'(1 << i);
    req = 4'b1111;
    for (int o = 0; o < 4; o++) begin
      for (int k = 1; k <= 8; k++) begin
        tick();
        check("t2_gnt", 32'(gnt), 32'(1 << o));
        check("t2_led", 32'(led), 32'(1 << o));
      end
      tick();
      check("t2_gap_gnt", 32'(gnt), 32'h0);
      check("t2_gap_led", 32'(led), 32'(1 << o));
    end
    tick();
    check("t2_wrap_gnt", 32'(gnt), 32'h1);
    check("t2_wrap_led", 32'(led), 32'h1);

    // 3: done[0] on the 3rd edge of its grant
    do_reset();
    req = 4'b0011;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("t3_own0", 32'(gnt), 32'h1);
    end
    done = 4'b0001;
    tick();
    done = '0;
    check("t3_gap", 32'(gnt), 32'h0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("t3_own1", 32'(gnt), 32'h2);
    end
    tick();
    check("t3_gap2", 32'(gnt), 32'h0);

    // 4: req[1] drops after 5 grant cycles, requester 3 takes over
    do_reset();
    data_a[1] = 4'hA;
    data_a[3] = 4'h8;
    req = 4'b1010;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("t4_own1", 32'(gnt), 32'h2);
    end
    req = 4'b1000;
    data_a[1] = 4'h5;
    tick();
    check("t4_gap_gnt",   32'(gnt), 32'h0);
    check("t4_gap_led",   32'(led), 32'hA);
    check("t4_gap_valid", 32'(led_valid), 32'h0);
    tick();
    check("t4_own3", 32'(gnt), 32'h8);
    check("t4_led3", 32'(led), 32'h8);

    // 5: reset during cycle 4 of a grant to requester 3
    do_reset();
    req = 4'b1000;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("t5_own3", 32'(gnt), 32'h8);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_gnt",  32'(gnt), 32'h0);
    check("t5_rst_led",  32'(led), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    tick();
    check("t5_regnt", 32'(gnt), 32'h8);

    // 6: done from a non-owner is ignored
    do_reset();
    req = 4'b0101;
    tick();
    check("t6_own0_first", 32'(gnt), 32'h1);
    done = 4'b0100;
    for (int k = 2; k <= 8; k++) begin
      tick();
      done = '0;
      check("t6_own0", 32'(gnt), 32'h1);
    end
    tick();
    check("t6_gap", 32'(gnt), 32'h0);
    tick();
    check("t6_own2", 32'(gnt), 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
